// File: rtl/gpio_debounce_bank_pkg.sv
// gpio_pkg: shared helpers for the GPIO debounce bank.
//   clog2_min1 : ceil(log2(v)), never less than 1 bit
//   deb_cnt_w  : width of a per-channel debounce counter
//   popcount   : number of set bits in a rise vector (up to POP_MAX_W channels)
package gpio_pkg;

  localparam int POP_MAX_W = 64;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // The counter only has to reach DEBOUNCE_CYCLES-1.
  function automatic int deb_cnt_w(input int cycles);
    return clog2_min1(cycles);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gpio_debounce_bank_if.sv
// gpio_debounce_bank_if: bundle of the bank's pin-side inputs and conditioned outputs.
//   master : drives raw_in, clr_flags, clr_count; observes the outputs
//   slave  : the debounce bank itself
interface gpio_debounce_bank_if #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16
);
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] clr_flags;
  logic                clr_count;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] event_flags;
  logic [CNT_W-1:0]    rise_count;

  modport master (
    output raw_in, clr_flags, clr_count,
    input  level_out, rise_pulse, fall_pulse, event_flags, rise_count
  );

  modport slave (
    input  raw_in, clr_flags, clr_count,
    output level_out, rise_pulse, fall_pulse, event_flags, rise_count
  );
endinterface

// File: rtl/gpio_debounce_bank_chan.sv
// gpio_debounce_chan: one input channel.
//   clk, rst : clock, asynchronous active-high reset
//   raw_i    : raw asynchronous pin level
//   level_o  : debounced level (registered)
//   rise_o   : one-cycle pulse on accepted 0->1
//   fall_o   : one-cycle pulse on accepted 1->0
module gpio_debounce_chan
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = deb_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};

  // The counter only runs while synced disagrees with the accepted level, so any
  // return to the old level before acceptance drops the count back to zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
        rise_d  = synced;
        fall_d  = ~synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser / debounce / edge-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_debounce_bank.sv
// gpio_debounce_bank: bank of CHANNELS debounced inputs with sticky rise flags
// and a saturating rise counter shared by all channels.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : slave side of gpio_debounce_bank_if
//              (raw_in, clr_flags, clr_count in; level_out, rise_pulse,
//               fall_pulse, event_flags, rise_count out)
// CHANNELS must not exceed gpio_pkg::POP_MAX_W.
module gpio_debounce_bank
  import gpio_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic                  clk,
  input logic                  rst,
  gpio_debounce_bank_if.slave  bus_io
);

  // One spare bit beyond CNT_W per doubling of CHANNELS keeps the sum overflow-free.
  localparam int SUM_W = CNT_W + clog2_min1(CHANNELS + 1);
  localparam logic [SUM_W-1:0] SAT_LIM = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [CHANNELS-1:0] level_w, rise_w, fall_w;
  logic [CHANNELS-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SUM_W-1:0]    sum;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    gpio_debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (bus_io.raw_in[g]),
      .level_o (level_w[g]),
      .rise_o  (rise_w[g]),
      .fall_o  (fall_w[g])
    );
  end

  // A rise and a clear in the same cycle leave the flag set.
  always_comb begin
    flags_d = (flags_q & ~bus_io.clr_flags) | rise_w;
  end

  // clr_count zeroes the base but still counts rises arriving this cycle.
  always_comb begin
    sum     = (bus_io.clr_count ? '0 : SUM_W'(count_q))
            + SUM_W'(popcount(POP_MAX_W'(rise_w)));
    count_d = (sum > SAT_LIM) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Event flag / rise counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  assign bus_io.level_out   = level_w;
  assign bus_io.rise_pulse  = rise_w;
  assign bus_io.fall_pulse  = fall_w;
  assign bus_io.event_flags = flags_q;
  assign bus_io.rise_count  = count_q;

endmodule

// File: tb/tb_gpio_debounce_bank.sv
module tb_gpio_debounce_bank;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_debounce_bank_if #(.CHANNELS(4), .CNT_W(16)) ifa ();
  gpio_debounce_bank_if #(.CHANNELS(4), .CNT_W(2))  ifs ();

  gpio_debounce_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus_io(ifa)
  );

  gpio_debounce_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .bus_io(ifs)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
    logic [3:0] flags;
    int         ca;
    int         cs;
  } ev_t;

  ev_t q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Expected pulse event, visible dly edges after the current one.
  function automatic void push(int dly, logic [3:0] rise, logic [3:0] fall,
                               logic [3:0] level, logic [3:0] flags, int ca, int cs);
    ev_t e;
    e.cyc = cyc + dly; e.rise = rise; e.fall = fall; e.level = level;
    e.flags = flags; e.ca = ca; e.cs = cs;
    q.push_back(e);
  endfunction

  task automatic set_in(logic [3:0] raw, logic [3:0] clrf, logic clrc);
    ifa.raw_in = raw;  ifa.clr_flags = clrf;  ifa.clr_count = clrc;
    ifs.raw_in = raw;  ifs.clr_flags = clrf;  ifs.clr_count = clrc;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: any pulse is an output event and must match the next expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && (ifa.rise_pulse !== 4'b0 || ifa.fall_pulse !== 4'b0)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: rise=%b fall=%b, none expected (cycle %0d)",
                 ifa.rise_pulse, ifa.fall_pulse, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk("ev_rise",  32'(ifa.rise_pulse), 32'(e.rise));
        chk("ev_fall",  32'(ifa.fall_pulse), 32'(e.fall));
        chk("ev_level", 32'(ifa.level_out), 32'(e.level));
        chk("ev_flags", 32'(ifa.event_flags), 32'(e.flags));
        chk("ev_count", 32'(ifa.rise_count), 32'(e.ca));
        chk("ev_count_sat", 32'(ifs.rise_count), 32'(e.cs));
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_level"}, 32'(ifa.level_out), 32'd0);
    chk({tag, "_rise"},  32'(ifa.rise_pulse), 32'd0);
    chk({tag, "_fall"},  32'(ifa.fall_pulse), 32'd0);
    chk({tag, "_flags"}, 32'(ifa.event_flags), 32'd0);
    chk({tag, "_count"}, 32'(ifa.rise_count), 32'd0);
    chk({tag, "_count_sat"}, 32'(ifs.rise_count), 32'd0);
  endtask

  int cs_pre  [4] = '{1, 2, 3, 3};
  int cs_post [4] = '{2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    set_in(4'b0000, 4'b0000, 1'b0);
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step(10);

    // single rise then fall on channel 0
    set_in(4'b0001, 4'b0000, 1'b0);
    push(6, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0);
    step(10);
    set_in(4'b0000, 4'b0000, 1'b0);
    push(6, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1, 1);
    step(10);

    // 3-cycle glitch rejected, 4-cycle pulse accepted
    set_in(4'b0010, 4'b0000, 1'b0);
    step(3);
    set_in(4'b0000, 4'b0000, 1'b0);
    step(10);
    chk("glitch_level", 32'(ifa.level_out), 32'h0);
    chk("glitch_flags", 32'(ifa.event_flags), 32'h1);
    chk("glitch_count", 32'(ifa.rise_count), 32'd1);
    set_in(4'b0010, 4'b0000, 1'b0);
    push(6, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 1, 1);
    step(4);
    set_in(4'b0000, 4'b0000, 1'b0);
    push(6, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 2, 2);
    step(10);

    // two simultaneous rises
    set_in(4'b1100, 4'b0000, 1'b0);
    push(6, 4'b1100, 4'b0000, 4'b1100, 4'b0011, 2, 2);
    step(10);
    chk("dual_flags", 32'(ifa.event_flags), 32'hf);
    chk("dual_count", 32'(ifa.rise_count), 32'd4);
    chk("dual_count_sat", 32'(ifs.rise_count), 32'd3);

    // clear low flags, then set-wins and clr_count with a coincident rise
    set_in(4'b1100, 4'b0011, 1'b0);
    step(1);
    set_in(4'b1100, 4'b0000, 1'b0);
    chk("clr_low_flags", 32'(ifa.event_flags), 32'hc);
    set_in(4'b1000, 4'b0000, 1'b0);
    push(6, 4'b0000, 4'b0100, 4'b1000, 4'b1100, 4, 3);
    step(10);
    set_in(4'b1100, 4'b0000, 1'b0);
    push(6, 4'b0100, 4'b0000, 4'b1100, 4'b1100, 4, 3);
    step(6);
    set_in(4'b1100, 4'b0100, 1'b1);
    step(1);
    set_in(4'b1100, 4'b0000, 1'b0);
    chk("set_wins_flags", 32'(ifa.event_flags), 32'hc);
    chk("clr_count_rise", 32'(ifa.rise_count), 32'd1);
    chk("clr_count_rise_sat", 32'(ifs.rise_count), 32'd1);
    step(10);
    set_in(4'b1100, 4'b1100, 1'b0);
    step(1);
    set_in(4'b1100, 4'b0000, 1'b0);
    chk("lone_clr_flags", 32'(ifa.event_flags), 32'h0);
    step(1);

    // four more separate rises on channel 0: 2-bit counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      set_in(4'b1101, 4'b0000, 1'b0);
      push(6, 4'b0001, 4'b0000, 4'b1101, (k == 0) ? 4'b0000 : 4'b0001, 1 + k, cs_pre[k]);
      step(10);
      set_in(4'b1100, 4'b0000, 1'b0);
      push(6, 4'b0000, 4'b0001, 4'b1100, 4'b0001, 2 + k, cs_post[k]);
      step(10);
    end
    chk("final_count", 32'(ifa.rise_count), 32'd5);
    chk("final_count_sat", 32'(ifs.rise_count), 32'd3);

    // asynchronous reset between edges while a debounce is in progress
    set_in(4'b1111, 4'b0000, 1'b0);
    step(2);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    set_in(4'b0000, 4'b0000, 1'b0);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("post_rst_level", 32'(ifa.level_out), 32'h0);
      chk("post_rst_flags", 32'(ifa.event_flags), 32'h0);
      chk("post_rst_count", 32'(ifa.rise_count), 32'd0);
    end

    chk("events_outstanding", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
